pixel_stream_tx: RTL and testbench
==================================

PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 Parameters SHALL be: COLS, default 16, active pixels per line (1..256); ROWS, default 16, lines per frame (1..256); HBLANK, default 2, idle cycles between lines (>=1); VBLANK, default 4, idle cycles after the last line (>=1).
REQ-002 Clk  input  1  sole clock, all logic on rising edge.
REQ-003 nReset  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  one-cycle request to transmit a frame.
REQ-005 cont  input  1  when high, frames repeat back-to-back without a new start.
REQ-006 rd_en  output  1  frame-buffer read strobe.
REQ-007 rd_i  output  8  column address of the read.
REQ-008 rd_j  output  8  row address of the read.
REQ-009 rd_data  input  8  frame-buffer data, valid exactly one cycle after rd_en.
REQ-010 Pixel  output  8  pixel value, meaningful only while Line is high.
REQ-011 Line  output  1  high for each active pixel of a line.
REQ-012 Frame  output  1  high from the first to the last active pixel of a frame, inclusive.
REQ-013 busy  output  1  high while a frame is in progress.
REQ-014 done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-015 The FSM SHALL have states IDLE, ACTIVE, HBLANK and VBLANK.
REQ-016 IDLE->ACTIVE SHALL occur on start=1; column and row counters are cleared on that transition.
REQ-017 In ACTIVE: rd_en=1, rd_i=column, rd_j=row; the column increments each cycle.
REQ-018 Leaving ACTIVE after column COLS-1: to HBLANK if row<ROWS-1, otherwise to VBLANK.
REQ-019 HBLANK SHALL last exactly HBLANK cycles, increment the row, clear the column and return to ACTIVE.
REQ-020 VBLANK SHALL last exactly VBLANK cycles counted after the last Line cycle; done=1 in the final cycle; next state is ACTIVE (new frame, counters cleared) if cont=1 in that cycle, else IDLE.
REQ-021 Pixel and Line SHALL be registered: Line(t)=rd_en(t-1), Pixel(t)=rd_data(t) captured from the read issued at t-1; Pixel=0 whenever Line=0.
REQ-022 Frame SHALL rise with the first Line of row 0, stay high through HBLANK gaps, and fall after the last Line of row ROWS-1.
REQ-023 busy SHALL be high in every cycle from the one after start is accepted through the done cycle inclusive; busy stays high across continuous frames.
REQ-024 start while busy SHALL be ignored; cont is sampled only in the done cycle.
REQ-025 rd_en, rd_i and rd_j SHALL be 0 outside ACTIVE.
REQ-026 Counters SHALL be sized for 256 without overflow; no wrap-around is visible on rd_i/rd_j.

Reset
REQ-027 nReset=1 at a rising edge SHALL force IDLE and clear all counters; all outputs are 0 in the following cycle, including mid-line and mid-frame; no done is issued for the aborted frame.
REQ-028 start coincident with nReset=1 SHALL be ignored.

Structure
REQ-029 The state encoding and the default geometry constants SHALL live in a shared package also used by the stream receiver.
REQ-030 One sub-module, blank_counter (a loadable down-counter with zero flag), SHALL time both HBLANK and VBLANK.

Verification
Use COLS=4, ROWS=3, HBLANK=2, VBLANK=3, buffer content 16*j+i; start at cycle 0.
REQ-031 Single frame: Line high in cycles 2-5, 8-11 and 14-17; Pixel 00-03, 10-13, 20-23; Frame high in cycles 2-17; done in cycle 20; busy high in cycles 1-20.
REQ-032 Read timing: rd_en high in cycles 1-4, 7-10 and 13-16 with matching rd_i/rd_j; zero elsewhere.
REQ-033 Continuous: cont=1 -> second frame's rd_en in cycle 21 and Line in cycle 22; busy never drops; done in cycles 20 and 40.
REQ-034 Ignored start: start pulse in cycle 9 -> waveform identical to REQ-031.
REQ-035 Mid-frame reset: nReset=1 in cycle 9 -> cycle 10 all outputs 0, no done; start in cycle 12 -> Line in cycles 14-17 with Pixel 00-03.
REQ-036 Degenerate geometry: COLS=1, ROWS=1 -> Line and Frame high in cycle 2 only, Pixel=00, done in cycle 5.

Source files
------------

// File: rtl/pixel_stream_tx_pkg.sv
// Shared definitions for the pixel stream transmitter and receiver:
// FSM state encoding, default frame geometry and counter types.
package pixel_stream_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    localparam int DEF_COLS   = 16;
    localparam int DEF_ROWS   = 16;
    localparam int DEF_HBLANK = 2;
    localparam int DEF_VBLANK = 4;

    localparam int CNT_W   = 8;
    localparam int BLANK_W = 16;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [BLANK_W-1:0] blank_t;

endpackage

// File: rtl/pixel_stream_tx_if.sv
// Frame-buffer read port, frame request controls and pixel stream outputs
// of the transmitter, bundled as one interface.
interface pixel_stream_tx_if;
    import pixel_stream_tx_pkg::*;

    logic       start;
    logic       cont;
    logic       rd_en;
    cnt_t       rd_i;
    cnt_t       rd_j;
    logic [7:0] rd_data;
    logic [7:0] Pixel;
    logic       Line;
    logic       Frame;
    logic       busy;
    logic       done;

    modport master (
        input  start, cont, rd_data,
        output rd_en, rd_i, rd_j, Pixel, Line, Frame, busy, done
    );

    modport slave (
        output start, cont, rd_data,
        input  rd_en, rd_i, rd_j, Pixel, Line, Frame, busy, done
    );

endinterface

// File: rtl/pixel_stream_tx_blank_counter.sv
// Loadable down-counter with a zero flag; times both blanking intervals.
module blank_counter
    import pixel_stream_tx_pkg::*;
(
    input  logic   Clk,
    input  logic   nReset,
    input  logic   load,
    input  blank_t load_val,
    output logic   zero
);

    blank_t cnt;

    always_ff @(posedge Clk) begin
        if (nReset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pixel_stream_tx.sv
// Raster transmitter: walks the frame buffer row by row and emits a
// line/frame-framed pixel stream with programmable blanking.
module pixel_stream_tx
    import pixel_stream_tx_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int HBLANK = DEF_HBLANK,
    parameter int VBLANK = DEF_VBLANK
) (
    input  logic               Clk,
    input  logic               nReset,
    pixel_stream_tx_if.master  bus
);

    localparam cnt_t   LAST_COL = cnt_t'(COLS - 1);
    localparam cnt_t   LAST_ROW = cnt_t'(ROWS - 1);
    // HBLANK counts down to zero inside the state; VBLANK gets one extra
    // count because it begins while the last Line cycle is still on the wire.
    localparam blank_t H_LOAD   = blank_t'(HBLANK - 1);
    localparam blank_t V_LOAD   = blank_t'(VBLANK);

    state_t state, state_nx;
    cnt_t   col, col_nx;
    cnt_t   row, row_nx;
    logic   blank_load;
    blank_t blank_val;
    logic   blank_zero;
    logic   line_p1;
    logic   frame_p1;

    blank_counter u_blank (
        .Clk      (Clk),
        .nReset   (nReset),
        .load     (blank_load),
        .load_val (blank_val),
        .zero     (blank_zero)
    );

    always_ff @(posedge Clk) begin
        if (nReset) begin
            state    <= ST_IDLE;
            col      <= '0;
            row      <= '0;
            line_p1  <= 1'b0;
            frame_p1 <= 1'b0;
        end else begin
            state    <= state_nx;
            col      <= col_nx;
            row      <= row_nx;
            line_p1  <= (state == ST_ACTIVE);
            frame_p1 <= (state == ST_ACTIVE) || (state == ST_HBLANK);
        end
    end

    always_comb begin
        state_nx   = state;
        col_nx     = col;
        row_nx     = row;
        blank_load = 1'b0;
        blank_val  = H_LOAD;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx = ST_ACTIVE;
                    col_nx   = '0;
                    row_nx   = '0;
                end
            end
            ST_ACTIVE: begin
                if (col == LAST_COL) begin
                    blank_load = 1'b1;
                    if (row == LAST_ROW) begin
                        state_nx  = ST_VBLANK;
                        blank_val = V_LOAD;
                    end else begin
                        state_nx = ST_HBLANK;
                    end
                end else begin
                    col_nx = col + 1'b1;
                end
            end
            ST_HBLANK: begin
                if (blank_zero) begin
                    state_nx = ST_ACTIVE;
                    col_nx   = '0;
                    row_nx   = row + 1'b1;
                end
            end
            ST_VBLANK: begin
                if (blank_zero) begin
                    col_nx   = '0;
                    row_nx   = '0;
                    state_nx = bus.cont ? ST_ACTIVE : ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Read issue in ACTIVE; pixel returns one cycle later alongside Line
    assign bus.rd_en = (state == ST_ACTIVE);
    assign bus.rd_i  = bus.rd_en ? col : '0;
    assign bus.rd_j  = bus.rd_en ? row : '0;
    assign bus.Line  = line_p1;
    assign bus.Pixel = line_p1 ? bus.rd_data : 8'h00;
    assign bus.Frame = frame_p1;
    assign bus.busy  = (state != ST_IDLE);
    assign bus.done  = (state == ST_VBLANK) && blank_zero;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx: 4x3 frame (single, ignored start,
// continuous, mid-frame reset) and a 1x1 degenerate frame.
module tb_pixel_stream_tx;
    import pixel_stream_tx_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pixel_stream_tx_if a ();
    pixel_stream_tx_if b ();

    pixel_stream_tx #(.COLS(4), .ROWS(3), .HBLANK(2), .VBLANK(3)) dut_a (
        .Clk    (clk),
        .nReset (rst_a),
        .bus    (a.master)
    );

    pixel_stream_tx #(.COLS(1), .ROWS(1), .HBLANK(2), .VBLANK(3)) dut_b (
        .Clk    (clk),
        .nReset (rst_b),
        .bus    (b.master)
    );

    // Frame buffer model holding 16*j+i, one-cycle read latency
    always @(posedge clk) begin
        if (a.rd_en) a.rd_data <= {a.rd_j[3:0], a.rd_i[3:0]};
        if (b.rd_en) b.rd_data <= {b.rd_j[3:0], b.rd_i[3:0]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int c, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
    endtask

    // Expected 4x3 waveform indexed by cycle relative to the accepted start
    function automatic bit e_line(input int e);
        return (e >= 2) && (e <= 17) && (((e - 2) % 6) < 4);
    endfunction
    function automatic int e_pixel(input int e);
        return e_line(e) ? 16 * ((e - 2) / 6) + ((e - 2) % 6) : 0;
    endfunction
    function automatic bit e_rd_en(input int e);
        return (e >= 1) && (e <= 16) && (((e - 1) % 6) < 4);
    endfunction
    function automatic int e_rd_i(input int e);
        return e_rd_en(e) ? (e - 1) % 6 : 0;
    endfunction
    function automatic int e_rd_j(input int e);
        return e_rd_en(e) ? (e - 1) / 6 : 0;
    endfunction

    task automatic check_a(input int c, input int e);
        check("rd_en", c, 32'(a.rd_en), 32'(e_rd_en(e)));
        check("rd_i",  c, 32'(a.rd_i),  32'(e_rd_i(e)));
        check("rd_j",  c, 32'(a.rd_j),  32'(e_rd_j(e)));
        check("Line",  c, 32'(a.Line),  32'(e_line(e)));
        check("Pixel", c, 32'(a.Pixel), 32'(e_pixel(e)));
        check("Frame", c, 32'(a.Frame), 32'((e >= 2) && (e <= 17)));
        check("done",  c, 32'(a.done),  32'(e == 20));
        check("busy",  c, 32'(a.busy),  32'((e >= 1) && (e <= 20)));
    endtask

    // mode 0 single, 1 start while busy, 2 continuous, 3 mid-frame reset
    task automatic run_a(input int mode, input int ncyc);
        int e;
        for (int c = 0; c <= ncyc; c++) begin
            tick();
            a.start = (c == 0) || (mode == 1 && c == 9) || (mode == 3 && c == 12);
            a.cont  = (mode == 2) && (c <= 20);
            rst_a   = (mode == 3) && (c == 9);
            e = c;
            if (mode == 2 && c > 20) e = c - 20;
            if (mode == 3 && c >= 10) e = (c >= 13) ? c - 12 : 0;
            check_a(c, e);
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        a.start = 1'b0;
        a.cont  = 1'b0;
        b.start = 1'b0;
        b.cont  = 1'b0;
        tick();
        tick();
        check_a(-1, 0);
        check("b_busy_rst", -1, 32'(b.busy), 32'd0);
        check("b_line_rst", -1, 32'(b.Line), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        check_a(-1, 0);

        run_a(0, 24);
        run_a(1, 24);
        run_a(2, 44);
        run_a(3, 34);

        for (int c = 0; c <= 8; c++) begin
            tick();
            b.start = (c == 0);
            check("b_rd_en", c, 32'(b.rd_en), 32'(c == 1));
            check("b_rd_i",  c, 32'(b.rd_i),  32'd0);
            check("b_rd_j",  c, 32'(b.rd_j),  32'd0);
            check("b_Line",  c, 32'(b.Line),  32'(c == 2));
            check("b_Pixel", c, 32'(b.Pixel), 32'd0);
            check("b_Frame", c, 32'(b.Frame), 32'(c == 2));
            check("b_done",  c, 32'(b.done),  32'(c == 5));
            check("b_busy",  c, 32'(b.busy),  32'((c >= 1) && (c <= 5)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
